// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU with registered outputs and a shift-add multiplier.
// Define ALU_OVF_EN to add the signed-overflow output ovf.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         select,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zflag
`ifdef ALU_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            carry_q, carry_d;
    logic            zflag_q, zflag_d;
    logic            out_valid_q, out_valid_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   alu_res;
    logic            alu_carry;
    logic            alu_ovf;
    logic [RW-1:0]   acc_step;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        unique case (op_e'(select))
            OP_ADD: begin
                alu_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a_ext & b_ext;
            OP_OR:   alu_res = a_ext | b_ext;
            OP_NAND: alu_res = ~(a_ext & b_ext);
            OP_NOR:  alu_res = ~(a_ext | b_ext);
            OP_XOR:  alu_res = a_ext ^ b_ext;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zflag_d     = zflag_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_e'(select) == OP_MUL) begin
                        mcand_d  = a_ext;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        carry_d     = alu_carry;
                        zflag_d     = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Final iteration: publish the accumulated product directly.
                if (cnt_q == LAST) begin
                    result_d    = acc_step;
                    carry_d     = 1'b0;
                    zflag_d     = (acc_step == '0);
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zflag_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zflag_q     <= zflag_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign zflag     = zflag_q;
    assign out_valid = out_valid_q;

`ifdef ALU_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ alu_ovf;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8.
// Covers ALU ops, MUL latency, backpressure and reset during MUL.
module tb_alu_seq_core;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     select;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zflag;
`ifdef ALU_OVF_EN
    logic           ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zflag     (zflag)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] s, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        select   = s;
        a        = x;
        b        = y;
        #1;
        chk("issue_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h5A;
        b        = 8'hC3;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] r,
                              input logic c, input logic z);
        chk({tag, "_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_r"}, 32'(result), 32'(r));
        chk({tag, "_c"}, 32'(carry), 32'(c));
        chk({tag, "_z"}, 32'(zflag), 32'(z));
    endtask

    task automatic wait_mul(input string tag);
        int n;
        int rdy_hi;
        n      = 0;
        rdy_hi = 0;
        chk({tag, "_v0"}, 32'(out_valid), 32'd0);
        while (!out_valid && n < 20) begin
            if (in_ready) rdy_hi++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_rdy"}, 32'(rdy_hi), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        select    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(result), 32'd0);
        chk("rst_c", 32'(carry), 32'd0);
        chk("rst_z", 32'(zflag), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'b000, 8'h55, 8'hAA);
        expect_res("add1", 16'h00FF, 1'b0, 1'b0);
        issue(3'b000, 8'hFF, 8'h01);
        expect_res("add2", 16'h0000, 1'b1, 1'b1);

        issue(3'b001, 8'hAA, 8'h55);
        expect_res("sub1", 16'h0055, 1'b0, 1'b0);
        issue(3'b001, 8'h55, 8'hAA);
        expect_res("sub2", 16'h00AB, 1'b1, 1'b0);

        issue(3'b010, 8'h55, 8'hAA);
        wait_mul("mul1");
        expect_res("mul1", 16'h3872, 1'b0, 1'b0);
        issue(3'b010, 8'h00, 8'hFF);
        wait_mul("mul2");
        expect_res("mul2", 16'h0000, 1'b0, 1'b1);

        issue(3'b011, 8'h55, 8'hAA);
        expect_res("and", 16'h0000, 1'b0, 1'b1);
        issue(3'b100, 8'h55, 8'hAA);
        expect_res("or", 16'h00FF, 1'b0, 1'b0);
        issue(3'b101, 8'h55, 8'hAA);
        expect_res("nand", 16'hFFFF, 1'b0, 1'b0);
        issue(3'b110, 8'h55, 8'hAA);
        expect_res("nor", 16'hFF00, 1'b0, 1'b0);
        issue(3'b111, 8'h55, 8'hAA);
        expect_res("xor", 16'h00FF, 1'b0, 1'b0);

        // Backpressure: hold ADD result while an OR request waits.
        issue(3'b000, 8'hFF, 8'h01);
        out_ready = 1'b0;
        expect_res("bp_add", 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        select   = 3'b100;
        a        = 8'h55;
        b        = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_v", 32'(out_valid), 32'd1);
            chk("bp_hold_r", 32'(result), 32'h0000);
            chk("bp_hold_c", 32'(carry), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_res("bp_or", 16'h00FF, 1'b0, 1'b0);

        // Reset in the 4th cycle of a MUL.
        issue(3'b010, 8'h55, 8'hAA);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_v", 32'(out_valid), 32'd0);
        chk("mrst_r", 32'(result), 32'd0);
        chk("mrst_c", 32'(carry), 32'd0);
        chk("mrst_z", 32'(zflag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("mrst_stale", 32'(seen), 32'd0);
        end
        chk("mrst_rdy", 32'(in_ready), 32'd1);
        issue(3'b000, 8'h01, 8'h02);
        expect_res("post_add", 16'h0003, 1'b0, 1'b0);

`ifdef ALU_OVF_EN
        chk("ovf_clr", 32'(ovf), 32'd0);
        issue(3'b000, 8'h7F, 8'h01);
        expect_res("ovf_add", 16'h0080, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
